// File: rtl/latch_seq_pkg.sv
// Shared types and default phase timing for the latch write sequencer.
// The build macro LATCH_WSEQ_READBACK_EN enables the CHECK state in the top.
package latch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 3;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/latch_seq_cnt.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
// Saturates at zero so an enable left high in the last cycle cannot wrap.
module latch_seq_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Turns write/clear requests into setup / gate-pulse / hold waveforms for a NAND D-latch bank.
// Define LATCH_WSEQ_READBACK_EN to add Q readback, a CHECK state, and err/err_sticky outputs.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_clr,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_clk,
    output logic             lat_rst,
    output logic             busy,
    output logic             done
`ifdef LATCH_WSEQ_READBACK_EN
    ,
    input  logic [WIDTH-1:0] lat_q,
    output logic             err,
    output logic             err_sticky
`endif
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (SETUP_CYC < 1 || SETUP_CYC > CNT_MAX) begin : g_bad_setup
        $error("latch_write_sequencer: SETUP_CYC out of range");
    end
    if (PULSE_CYC < 1 || PULSE_CYC > CNT_MAX) begin : g_bad_pulse
        $error("latch_write_sequencer: PULSE_CYC out of range");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > CNT_MAX) begin : g_bad_hold
        $error("latch_write_sequencer: HOLD_CYC out of range");
    end

    // Handshake: a request transfers on a rising edge where req_valid and req_ready
    // are both high; req_ready is high only in IDLE and nothing is queued while busy.

    state_t           state, state_next;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_count;

    logic [WIDTH-1:0] d_next;
    logic             clk_next, rst_next, done_next, finishing;

    latch_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_val    = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = SETUP;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_next = PULSE;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_next = HOLD;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
`ifdef LATCH_WSEQ_READBACK_EN
                    state_next = CHECK;
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch-side outputs are computed from the next state and registered, so the
    // asynchronous latches only ever see clean flop outputs.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        finishing = (state != IDLE) && (state_next == IDLE);
        d_next    = lat_d;
        rst_next  = lat_rst;
        if ((state == IDLE) && req_valid) begin
            d_next   = req_clr ? '0 : req_data;
            rst_next = req_clr;
        end
        if (finishing) begin
            rst_next = 1'b0;
        end
        clk_next  = (state_next == PULSE);
        done_next = finishing;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_d   <= '0;
            lat_clk <= 1'b0;
            lat_rst <= 1'b0;
            done    <= 1'b0;
        end else begin
            lat_d   <= d_next;
            lat_clk <= clk_next;
            lat_rst <= rst_next;
            done    <= done_next;
        end
    end

`ifdef LATCH_WSEQ_READBACK_EN
    // lat_d already holds the expected value (0 for a clear) throughout CHECK.
    logic mismatch;
    assign mismatch = (state == CHECK) && (lat_q != lat_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err <= mismatch;
            if (mismatch) begin
                err_sticky <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer: per-cycle vector tables plus corner sequences.
// Also covers readback when LATCH_WSEQ_READBACK_EN is defined.
module tb_latch_write_sequencer;

`ifdef LATCH_WSEQ_READBACK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int DONE_CYC = 8 + EXTRA;

    typedef struct {
        logic [7:0] d;
        logic       gate;
        logic       lrst;
        logic       ready;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, req_clr;
    logic [7:0] req_data;
    logic       req_ready, lat_clk, lat_rst, busy, done;
    logic [7:0] lat_d;

    logic       s_valid, s_clr;
    logic [7:0] s_data;
    logic       s_ready, s_clk, s_rst, s_busy, s_done;
    logic [7:0] s_d;

    int total = 0;
    int bad   = 0;
    int accepts;
    vec_t vecs[0:15];

`ifdef LATCH_WSEQ_READBACK_EN
    logic       q_force;
    logic [7:0] lat_q;
    logic       err, err_sticky, s_err, s_err_sticky;
    assign lat_q = q_force ? (lat_d ^ 8'h01) : lat_d;
`endif

    latch_write_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_clr(req_clr), .lat_d(lat_d), .lat_clk(lat_clk),
        .lat_rst(lat_rst), .busy(busy), .done(done)
`ifdef LATCH_WSEQ_READBACK_EN
        , .lat_q(lat_q), .err(err), .err_sticky(err_sticky)
`endif
    );

    latch_write_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready),
        .req_data(s_data), .req_clr(s_clr), .lat_d(s_d), .lat_clk(s_clk),
        .lat_rst(s_rst), .busy(s_busy), .done(s_done)
`ifdef LATCH_WSEQ_READBACK_EN
        , .lat_q(s_d), .err(s_err), .err_sticky(s_err_sticky)
`endif
    );

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) accepts++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected waveform for a default-parameter operation, indexed by cycle after accept.
    task automatic fill_table(input logic [7:0] d, input logic clr);
        for (int k = 1; k <= 7; k++) begin
            vecs[k] = '{d, (k >= 3 && k <= 5), clr, 1'b0, 1'b1, 1'b0};
        end
`ifdef LATCH_WSEQ_READBACK_EN
        vecs[8] = '{d, 1'b0, clr, 1'b0, 1'b1, 1'b0};
`endif
        vecs[DONE_CYC] = '{d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    endtask

    task automatic start_op(input logic [7:0] data, input logic clr);
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = data;
        req_clr   = clr;
        chk("ready_c0", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 8'($urandom_range(0, 255));
        req_clr   = 1'($urandom_range(0, 1));
    endtask

    task automatic run_table(input string name);
        for (int k = 1; k <= DONE_CYC; k++) begin
            @(negedge clk);
            chk($sformatf("%s_d_c%0d", name, k), lat_d, vecs[k].d);
            chk($sformatf("%s_gate_c%0d", name, k), lat_clk, vecs[k].gate);
            chk($sformatf("%s_lrst_c%0d", name, k), lat_rst, vecs[k].lrst);
            chk($sformatf("%s_ready_c%0d", name, k), req_ready, vecs[k].ready);
            chk($sformatf("%s_busy_c%0d", name, k), busy, vecs[k].busy);
            chk($sformatf("%s_done_c%0d", name, k), done, vecs[k].done);
        end
    endtask

    initial begin
        logic seen;
        rst = 1'b1; req_valid = 1'b0; req_data = '0; req_clr = 1'b0;
        s_valid = 1'b0; s_data = '0; s_clr = 1'b0;
        accepts = 0;
`ifdef LATCH_WSEQ_READBACK_EN
        q_force = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lat_d", lat_d, 8'h00);
        chk("rst_gate", lat_clk, 1'b0);
        chk("rst_lrst", lat_rst, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // Plain write
        fill_table(8'hA5, 1'b0);
        start_op(8'hA5, 1'b0);
        run_table("wr");
        @(negedge clk);
        chk("wr_idle_hold_d", lat_d, 8'hA5);
        chk("wr_idle_done", done, 1'b0);

        // Clear: data ignored, lat_d forced to zero, lat_rst spans the operation
        fill_table(8'h00, 1'b1);
        start_op(8'hFF, 1'b1);
        run_table("clr");

        // Back-to-back with a request held valid throughout the first operation
        @(negedge clk);
        accepts   = 0;
        req_valid = 1'b1;
        req_data  = 8'h3C;
        req_clr   = 1'b0;
        @(posedge clk);
        #1;
        req_data = 8'hC3;
        for (int k = 1; k <= DONE_CYC; k++) begin
            @(negedge clk);
            if (k < DONE_CYC) chk($sformatf("b2b_ready_c%0d", k), req_ready, 1'b0);
            chk($sformatf("b2b_d1_c%0d", k), lat_d, 8'h3C);
        end
        chk("b2b_done1", done, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = DONE_CYC + 1; k <= 2 * DONE_CYC; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_d2_c%0d", k), lat_d, 8'hC3);
            chk($sformatf("b2b_gate_c%0d", k), lat_clk,
                (k >= DONE_CYC + 3) && (k <= DONE_CYC + 5));
            chk($sformatf("b2b_done_c%0d", k), done, k == 2 * DONE_CYC);
        end
        chk("b2b_accepts", accepts, 2);

        // Reset in the middle of the gate pulse
        start_op(8'h77, 1'b0);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        chk("rstmid_gate_c4", lat_clk, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_gate", lat_clk, 1'b0);
        chk("rstmid_d", lat_d, 8'h00);
        chk("rstmid_ready", req_ready, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("rstmid_no_done", seen, 1'b0);

        // Minimum phase lengths on the second instance
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h96;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k <= 4 + EXTRA; k++) begin
            @(negedge clk);
            chk($sformatf("min_d_c%0d", k), s_d, 8'h96);
            chk($sformatf("min_gate_c%0d", k), s_clk, k == 2);
            chk($sformatf("min_done_c%0d", k), s_done, k == 4 + EXTRA);
            chk($sformatf("min_ready_c%0d", k), s_ready, k == 4 + EXTRA);
        end

`ifdef LATCH_WSEQ_READBACK_EN
        // Readback matches
        q_force = 1'b0;
        start_op(8'h5A, 1'b0);
        for (int k = 1; k <= DONE_CYC; k++) @(negedge clk);
        chk("rb_ok_done", done, 1'b1);
        chk("rb_ok_err", err, 1'b0);
        chk("rb_ok_sticky", err_sticky, 1'b0);
        // Readback mismatch, sticky flag persists until reset
        q_force = 1'b1;
        start_op(8'h5A, 1'b0);
        for (int k = 1; k <= DONE_CYC; k++) @(negedge clk);
        chk("rb_bad_done", done, 1'b1);
        chk("rb_bad_err", err, 1'b1);
        q_force = 1'b0;
        @(negedge clk);
        chk("rb_bad_err_pulse", err, 1'b0);
        chk("rb_bad_sticky", err_sticky, 1'b1);
        start_op(8'h11, 1'b0);
        for (int k = 1; k <= DONE_CYC; k++) @(negedge clk);
        chk("rb_next_err", err, 1'b0);
        chk("rb_next_sticky", err_sticky, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rb_rst_sticky", err_sticky, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
